pe_lx: RTL and testbench
========================

# pe_lx

Parametrised successor processing element for the RAVEN systolic array. It supports the streaming GEMM multiply-accumulate and an iterative unary mode (div / exp / log). Unary functions are evaluated as an (ITER+1)-term Horner polynomial over coefficients streamed on the weight lane, under a start/busy/done handshake. Arithmetic is fixed-point Q(INT_BW).(FRA_BW) with saturating accumulation, and the block drops into the same array slot as the current GEMM/unary PE.

## Interface
- INT_BW, 5: integer bits of operand format (sign excluded)
- FRA_BW, 10: fraction bits of operand format
- MUL_BW, 16: operand width; must equal 1+INT_BW+FRA_BW
- ACC_BW, 32: accumulator width; must be ≥ 2*MUL_BW
- ITER, 4: Horner steps after the initial coefficient, ≥1; total coefficients ITER+1
- clk  in  1  clock; one clock, all state on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- gemm_uno  in  2  00 gemm, 01 div, 10 exp, 11 log
- start_i  in  1  unary launch request
- x_i  in  MUL_BW  signed activation / unary argument
- wc_i  in  MUL_BW  signed weight (gemm) / coefficient (unary)
- o_i  in  ACC_BW  signed partial sum from neighbour
- x_o  out  MUL_BW  registered x_i forward
- wc_o  out  MUL_BW  registered wc_i forward
- o_o  out  ACC_BW  accumulator register oreg
- res_o  out  MUL_BW  trunc(oreg)
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse in DONE

## Operation
- Formats: operands signed Q(INT_BW).(FRA_BW). Accumulator is signed ACC_BW with 2*FRA_BW fraction bits. align(c) = sign-extend(c) << FRA_BW.
- sat_acc(v): clamps the full-precision sum to [-2^(ACC_BW-1), 2^(ACC_BW-1)-1]. No wrap-around anywhere.
- trunc(a) rules:
  - a > 2^(INT_BW+2FRA_BW)-1 → 0x7FFF (MUL_BW max)
  - a < -2^(INT_BW+2FRA_BW) → 0x8000
  - otherwise a[FRA_BW+MUL_BW-1 : FRA_BW], i.e. floor.
- Forward regs: wreg<=wc_i and ireg<=x_i every cycle in every state. x_o=ireg, wc_o=wreg.
- FSM states: IDLE, RUN, DONE.
- IDLE, gemm_uno==00: oreg <= sat_acc(wreg*ireg + o_i). start_i is ignored.
- IDLE, gemm_uno!=00: oreg holds. On start_i=1, in the same cycle:
  - latch mode
  - xreg <= x_i for exp; 1.0−x_i for div; x_i−1.0 for log. The subtraction saturates to MUL_BW.
  - oreg <= align(wc_i) (leading coefficient c_ITER)
  - cnt <= ITER
  - → RUN
- RUN: each cycle:
  - oreg <= sat_acc(trunc(oreg)*xreg + align(wc_i))
  - cnt <= cnt−1
  - on cnt==1 → DONE
  - gemm_uno and start_i are ignored.
- DONE: oreg holds and done_o=1. Next cycle → IDLE.
- A new start is accepted the cycle after DONE at the earliest.
- The result stays on o_o/res_o until oreg is next written.

## Timing
- Reset values: all registers 0, FSM IDLE. Outputs x_o, wc_o, o_o, res_o, busy_o, done_o all 0.
- rst_n assertion mid-RUN aborts immediately; no done_o is produced.
- GEMM latency: operands at x_i/wc_i in cycle t register at t+1. Their product, plus o_i sampled at t+1, appears on o_o at t+2. Throughput is one result per cycle.
- Unary timing:
  - start accepted at edge t0 with c_ITER on wc_i.
  - Coefficients c_ITER−1 … c_0 are presented on cycles t0+1 … t0+ITER, one per cycle, highest order first.
  - busy_o high for cycles t0+1 … t0+ITER.
  - done_o high at cycle t0+ITER+1, with the final value on o_o.
  - Launch-to-done latency is ITER+1 cycles.
- Coefficient lane: the wc_i consumed in RUN is also forwarded on wc_o, so a column of PEs can share one coefficient stream.
- Simultaneous start_i with gemm_uno==00: no launch; GEMM update proceeds.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release → IDLE, busy_o=0.
- GEMM: wc_i=0x0400, x_i=0x0800 at t, o_i=0x00100000 at t+1 → o_o=0x00300000 and res_o=0x0C00 at t+2. Also stream 8 back-to-back pairs and check each result.
- Saturation: wc_i=x_i=0x7FFF, o_i=0x7FFFFFFF → o_o=0x7FFFFFFF. Negated case (0x8000 × 0x7FFF, o_i=0x80000000) → 0x80000000.
- Exp, x_i=0x0400, five coefficients 0x0400 (ITER=4):
  - busy_o high 4 cycles, then done_o pulse
  - o_o=0x00500000, res_o=0x1400
  - same with x_i=0 → 0x00100000
- Div, x_i=0x0400 (xreg=0), coefficients 0x0400 each → 0x00100000. Toggling gemm_uno and start_i during RUN has no effect.
- Reset mid-RUN at cycle t0+2 → outputs 0 and no done_o. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/pe_lx.sv
// Systolic PE: saturating fixed-point GEMM MAC plus iterative Horner unary (div/exp/log).
// Latency: GEMM result 2 cycles after operands; unary done_o ITER+1 cycles after launch.
// Backpressure: none; start/busy/done handshake, new launch accepted only from IDLE.
module pe_lx #(
   parameter int INT_BW = 5,
   parameter int FRA_BW = 10,
   parameter int MUL_BW = 16,
   parameter int ACC_BW = 32,
   parameter int ITER   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        gemm_uno,
   input  logic              start_i,
   input  logic [MUL_BW-1:0] x_i,
   input  logic [MUL_BW-1:0] wc_i,
   input  logic [ACC_BW-1:0] o_i,
   output logic [MUL_BW-1:0] x_o,
   output logic [MUL_BW-1:0] wc_o,
   output logic [ACC_BW-1:0] o_o,
   output logic [MUL_BW-1:0] res_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int SUM_BW = ACC_BW + 1;
   localparam int PRD_BW = 2 * MUL_BW;
   localparam int CNT_BW = $clog2(ITER + 1);
   localparam int TR_BW  = INT_BW + 2 * FRA_BW;

   localparam logic [SUM_BW-1:0] ACC_MAX = {2'b00, {(ACC_BW-1){1'b1}}};
   localparam logic [SUM_BW-1:0] ACC_MIN = {2'b11, {(ACC_BW-1){1'b0}}};
   localparam logic [ACC_BW-1:0] TR_MAX  = {{(ACC_BW-TR_BW){1'b0}}, {TR_BW{1'b1}}};
   localparam logic [ACC_BW-1:0] TR_MIN  = {{(ACC_BW-TR_BW){1'b1}}, {TR_BW{1'b0}}};
   localparam logic [MUL_BW-1:0] MUL_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
   localparam logic [MUL_BW-1:0] MUL_MIN = {1'b1, {(MUL_BW-1){1'b0}}};
   localparam logic [MUL_BW:0]   ONE     = {{(MUL_BW-FRA_BW){1'b0}}, 1'b1, {FRA_BW{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [MUL_BW-1:0]   ireg, wreg, xreg;
   logic [ACC_BW-1:0]   oreg;
   logic [CNT_BW-1:0]   cnt;

   logic [PRD_BW-1:0]   gemm_prd, horn_prd;
   logic [SUM_BW-1:0]   gemm_sum, horn_sum;
   logic [MUL_BW:0]     x_ext, x_diff;
   logic [MUL_BW-1:0]   x_launch;

   function automatic logic [PRD_BW-1:0] sx_mul(input logic [MUL_BW-1:0] v);
      return {{MUL_BW{v[MUL_BW-1]}}, v};
   endfunction

   function automatic logic [SUM_BW-1:0] sx_prd(input logic [PRD_BW-1:0] p);
      return {{(SUM_BW-PRD_BW){p[PRD_BW-1]}}, p};
   endfunction

   function automatic logic [SUM_BW-1:0] sx_acc(input logic [ACC_BW-1:0] a);
      return {a[ACC_BW-1], a};
   endfunction

   function automatic logic [ACC_BW-1:0] align(input logic [MUL_BW-1:0] c);
      return {{(ACC_BW-MUL_BW-FRA_BW){c[MUL_BW-1]}}, c, {FRA_BW{1'b0}}};
   endfunction

   function automatic logic [ACC_BW-1:0] sat_acc(input logic [SUM_BW-1:0] v);
      if ($signed(v) > $signed(ACC_MAX)) return ACC_MAX[ACC_BW-1:0];
      if ($signed(v) < $signed(ACC_MIN)) return ACC_MIN[ACC_BW-1:0];
      return v[ACC_BW-1:0];
   endfunction

   function automatic logic [MUL_BW-1:0] trunc(input logic [ACC_BW-1:0] a);
      if ($signed(a) > $signed(TR_MAX)) return MUL_MAX;
      if ($signed(a) < $signed(TR_MIN)) return MUL_MIN;
      return a[FRA_BW+MUL_BW-1:FRA_BW];
   endfunction

   // Operands are sign-extended to full product width, so unsigned multiply gives the signed result.
   assign gemm_prd = sx_mul(wreg) * sx_mul(ireg);
   assign horn_prd = sx_mul(res_o) * sx_mul(xreg);
   assign gemm_sum = sx_prd(gemm_prd) + sx_acc(o_i);
   assign horn_sum = sx_prd(horn_prd) + sx_acc(align(wc_i));

   always_comb begin
      x_ext = {x_i[MUL_BW-1], x_i};
      case (gemm_uno)
         2'b01:   x_diff = ONE - x_ext;
         2'b11:   x_diff = x_ext - ONE;
         default: x_diff = x_ext;
      endcase
      if (x_diff[MUL_BW] != x_diff[MUL_BW-1])
         x_launch = x_diff[MUL_BW] ? MUL_MIN : MUL_MAX;
      else
         x_launch = x_diff[MUL_BW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ireg  <= '0;
         wreg  <= '0;
         xreg  <= '0;
         oreg  <= '0;
         cnt   <= '0;
      end else begin
         ireg <= x_i;
         wreg <= wc_i;
         case (state)
            IDLE: begin
               if (gemm_uno == 2'b00) begin
                  oreg <= sat_acc(gemm_sum);
               end else if (start_i) begin
                  xreg  <= x_launch;
                  oreg  <= align(wc_i);
                  cnt   <= CNT_BW'(ITER);
                  state <= RUN;
               end
            end
            RUN: begin
               oreg <= sat_acc(horn_sum);
               cnt  <= cnt - CNT_BW'(1);
               if (cnt == CNT_BW'(1))
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign x_o    = ireg;
   assign wc_o   = wreg;
   assign o_o    = oreg;
   assign res_o  = trunc(oreg);
   assign busy_o = (state == RUN);
   assign done_o = (state == DONE);

endmodule

// File: tb/tb_pe_lx.sv
// Scoreboard bench for pe_lx: stimulus pushes cycle-tagged expectations, a negedge monitor checks them.
module tb_pe_lx;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  gemm_uno;
   logic        start_i;
   logic [15:0] x_i, wc_i;
   logic [31:0] o_i;
   logic [15:0] x_o, wc_o, res_o;
   logic [31:0] o_o;
   logic        busy_o, done_o;

   pe_lx dut (
      .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .start_i(start_i),
      .x_i(x_i), .wc_i(wc_i), .o_i(o_i),
      .x_o(x_o), .wc_o(wc_o), .o_o(o_o), .res_o(res_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          id;
      logic [31:0] o;
      logic [15:0] r;
      logic        busy;
      logic        done;
      logic        chk_o;
      logic [15:0] xo;
      logic [15:0] wo;
      logic        chk_f;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input int id, input logic [31:0] o, input logic [15:0] r,
                       input logic busy, input logic done, input logic chk_o,
                       input logic [15:0] xo, input logic [15:0] wo, input logic chk_f);
      exp_t e;
      e.cyc = c; e.id = id; e.o = o; e.r = r; e.busy = busy; e.done = done;
      e.chk_o = chk_o; e.xo = xo; e.wo = wo; e.chk_f = chk_f;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every expectation tagged with the current cycle; done_o elsewhere is spurious.
   always @(negedge clk) begin
      exp_t e;
      bit   hit;
      bit   ok;
      hit = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL missed chk%0d: scheduled cyc %0d, now cyc %0d", e.id, e.cyc, cyc);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         hit = 1'b1;
         ok = (busy_o === e.busy) && (done_o === e.done);
         if (e.chk_o) ok = ok && (o_o === e.o) && (res_o === e.r);
         if (e.chk_f) ok = ok && (x_o === e.xo) && (wc_o === e.wo);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL chk%0d cyc=%0d: got o_o=%h res_o=%h busy=%b done=%b x_o=%h wc_o=%h; want o_o=%h res_o=%h busy=%b done=%b x_o=%h wc_o=%h (chk_o=%b chk_f=%b)",
                     e.id, cyc, o_o, res_o, busy_o, done_o, x_o, wc_o,
                     e.o, e.r, e.busy, e.done, e.xo, e.wo, e.chk_o, e.chk_f);
         end
      end
      if (!hit && rst_n === 1'b1) begin
         n_cmp++;
         if (done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL spurious_done cyc=%0d: got done_o=%b, want 0", cyc, done_o);
         end
      end
   end

   // GEMM table: weight, activation, neighbour partial sum, expected o_o, expected res_o.
   localparam int N = 11;
   logic [15:0] sw [N] = '{16'h0400, 16'h8000, 16'h0800, 16'hFC00, 16'h0200, 16'hFE00,
                           16'h0001, 16'hFFFF, 16'h7C00, 16'h7FFF, 16'h8000};
   logic [15:0] sx [N] = '{16'h0800, 16'h0400, 16'h0C00, 16'h0400, 16'h0200, 16'h0600,
                           16'h0001, 16'h0001, 16'h7C00, 16'h7FFF, 16'h7FFF};
   logic [31:0] so [N] = '{32'h00100000, 32'h0, 32'h0, 32'h0, 32'h00100000, 32'h0,
                           32'h0, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h80000000};
   logic [31:0] se [N] = '{32'h00300000, 32'hFE000000, 32'h00600000, 32'hFFF00000, 32'h00140000,
                           32'hFFF40000, 32'h00000001, 32'hFFFFFFFF, 32'h3C100000, 32'h7FFFFFFF,
                           32'h80000000};
   logic [15:0] sr [N] = '{16'h0C00, 16'h8000, 16'h1800, 16'hFC00, 16'h0500, 16'hFD00,
                           16'h0000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000};

   logic [15:0] c_one [5] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
   logic [15:0] c_log [5] = '{16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0200};
   logic [15:0] c_sat [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0000};

   task automatic run_unary(input logic [1:0] mode, input logic [15:0] x, input logic [15:0] c [5],
                            input logic [31:0] eo, input logic [15:0] er, input bit toggle, input int id);
      int s;
      s = cyc;
      gemm_uno = mode; start_i = 1'b1; x_i = x; wc_i = c[0]; o_i = 32'h0;
      for (int k = 1; k <= 4; k++) push(s + k, id, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      push(s + 5, id, eo, er, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0);
      push(s + 6, id, eo, er, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         wc_i = c[k];
         x_i  = 16'($urandom);
         o_i  = $urandom;
         if (toggle) begin
            gemm_uno = 2'(k);
            start_i  = (k % 2 == 1);
         end else begin
            start_i = 1'b0;
         end
      end
      tick();
      gemm_uno = mode; start_i = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      int s;
      int w;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gemm_uno = 2'($urandom); start_i = 1'($urandom);
         x_i = 16'($urandom); wc_i = 16'($urandom); o_i = $urandom;
         tick();
         push(cyc, 1, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
      end
      gemm_uno = 2'b01; start_i = 1'b0; x_i = 16'h0; wc_i = 16'h0; o_i = 32'h0;
      rst_n = 1'b1;
      push(cyc, 2, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
      push(cyc + 1, 3, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
      tick();
      tick();

      // GEMM stream, with a start request ignored in GEMM mode
      gemm_uno = 2'b00;
      for (int k = 0; k <= N; k++) begin
         start_i = (k == 3);
         if (k < N) begin
            x_i = sx[k]; wc_i = sw[k];
         end else begin
            x_i = 16'h0; wc_i = 16'h0;
         end
         if (k > 0) begin
            o_i = so[k-1];
            push(cyc + 1, 100 + k, se[k-1], sr[k-1], 1'b0, 1'b0, 1'b1, x_i, wc_i, 1'b1);
         end else begin
            o_i = 32'h0;
            push(cyc + 1, 100 + k, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, x_i, wc_i, 1'b1);
         end
         tick();
      end

      run_unary(2'b10, 16'h0400, c_one, 32'h00500000, 16'h1400, 1'b0, 200);
      run_unary(2'b10, 16'h0000, c_one, 32'h00100000, 16'h0400, 1'b0, 201);
      run_unary(2'b01, 16'h0400, c_one, 32'h00100000, 16'h0400, 1'b1, 202);
      run_unary(2'b11, 16'h0C00, c_log, 32'h01080000, 16'h4200, 1'b0, 203);
      run_unary(2'b11, 16'h8000, c_sat, 32'hFE000000, 16'h8000, 1'b0, 204);
      run_unary(2'b01, 16'h8000, c_sat, 32'h01FFFC00, 16'h7FFF, 1'b0, 205);

      // Reset during RUN aborts without done_o
      s = cyc;
      gemm_uno = 2'b10; start_i = 1'b1; x_i = 16'h0400; wc_i = 16'h0400;
      push(s + 1, 300, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      start_i = 1'b0;
      tick();
      rst_n = 1'b0;
      push(cyc, 301, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         push(cyc, 302, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
      end
      rst_n = 1'b1;
      tick();
      run_unary(2'b10, 16'h0000, c_one, 32'h00100000, 16'h0400, 1'b0, 303);

      w = 0;
      while (exp_q.size() > 0 && w < 20) begin
         tick();
         w++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
